mem_resp_stage: RTL and testbench



---
 rtl/mycpu_pkg.sv | 57 +++++
 rtl/load_align.sv | 55 +++++
 rtl/mem_resp_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_resp_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the MIPS memory stage: bus widths, load type
// codes, es_to_ms bus field positions and the cp0 side-band layout.
package mycpu_pkg;

  localparam int ES_TO_MS_BUS_WD = 128;
  localparam int MS_TO_WS_BUS_WD = 91;
  localparam int MS_TO_DS_BUS_WD = 43;

  // Load type codes carried in es_to_ms_bus; 7 is an alias of a plain word load.
  typedef enum logic [2:0] {
    LD_W   = 3'd0,
    LD_B   = 3'd1,
    LD_BU  = 3'd2,
    LD_H   = 3'd3,
    LD_HU  = 3'd4,
    LD_WL  = 3'd5,
    LD_WR  = 3'd6,
    LD_W7  = 3'd7
  } ld_type_e;

  // es_to_ms_bus field positions (LSB of each field, or the bit itself).
  localparam int EM_PC_LSB      = 0;
  localparam int EM_ALU_LSB     = 32;
  localparam int EM_RT_LSB      = 64;
  localparam int EM_DEST_LSB    = 96;
  localparam int EM_RF_WE_LSB   = 101;
  localparam int EM_REQ_BIT     = 105;
  localparam int EM_LD_TYPE_LSB = 106;
  localparam int EM_IS_LOAD_BIT = 109;
  localparam int EM_EXCODE_LSB  = 110;
  localparam int EM_EX_BIT      = 115;
  localparam int EM_BD_BIT      = 116;
  localparam int EM_C0_LSB      = 117;

  // cp0 side-band bus: {eret, mfc0, mtc0, cp0_addr[7:0]}.
  localparam int C0_ERET_BIT = 10;
  localparam int C0_MFC0_BIT = 9;

  // Per-instruction response state: waiting for data, or data buffered.
  typedef enum logic {
    RESP_WAIT = 1'b0,
    RESP_HAVE = 1'b1
  } resp_state_e;

  // Byte-wise merge: a set mask bit takes the byte from word, else from rt.
  function automatic logic [31:0] merge_bytes(input logic [3:0] mask,
                                              input logic [31:0] word,
                                              input logic [31:0] rt);
    logic [31:0] r;
    r = rt;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction and LWL/LWR merge.
// Produces the register result and the byte write mask for one load.
module load_align
  import mycpu_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result,
  output logic [3:0]  rf_we_mask
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  lwl_shamt;
  logic [4:0]  lwr_shamt;
  logic [31:0] lwl_word;
  logic [31:0] lwr_word;
  logic [3:0]  lwl_mask;
  logic [3:0]  lwr_mask;

  assign sel_byte  = rdata[{addr_low, 3'b000} +: 8];
  assign sel_half  = addr_low[1] ? rdata[31:16] : rdata[15:0];

  // LWL shifts by 3-a bytes; ~a equals 3-a for a two-bit address.
  assign lwl_shamt = {~addr_low, 3'b000};
  assign lwr_shamt = {addr_low, 3'b000};
  assign lwl_word  = rdata << lwl_shamt;
  assign lwr_word  = rdata >> lwr_shamt;
  assign lwl_mask  = 4'b1111 << (~addr_low);
  assign lwr_mask  = 4'b1111 >> addr_low;

  // Select the extracted value and write mask by load type.
  always_comb begin
    result     = rdata;
    rf_we_mask = 4'b1111;
    case (ld_type_e'(ld_type))
      LD_B:  result = {{24{sel_byte[7]}}, sel_byte};
      LD_BU: result = {24'b0, sel_byte};
      LD_H:  result = {{16{sel_half[15]}}, sel_half};
      LD_HU: result = {16'b0, sel_half};
      LD_WL: begin
        result     = merge_bytes(lwl_mask, lwl_word, rt_value);
        rf_we_mask = lwl_mask;
      end
      LD_WR: begin
        result     = merge_bytes(lwr_mask, lwr_word, rt_value);
        rf_we_mask = lwr_mask;
      end
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MIPS memory stage: holds one instruction from ES, waits for its data-SRAM
// response, aligns load data and hands the result to write-back.
// Responses belonging to flushed instructions are counted and dropped.
// Optional: define MS_FWD_EN to forward the final result to decode; without
// it the stage only raises an interlock whenever it will write a register.
//
// Handshake: an upstream transfer happens on a cycle where
// es_to_ms_valid && ms_allowin; a downstream transfer happens on a cycle where
// ms_to_ws_valid && ws_allowin. Valid never depends on the receiver's allowin.
module mem_resp_stage
  import mycpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       ws_allowin,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  input  logic                       es_req_inflight,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  resp_state_e                resp_state;
  resp_state_e                resp_state_next;
  logic [31:0]                data_buf;
  logic [1:0]                 discard_cnt;

  logic [10:0] ms_c0_bus;
  logic        ms_bd;
  logic        ms_ex_flag;
  logic [4:0]  ms_excode;
  logic        ms_is_load;
  logic [2:0]  ms_ld_type;
  logic        ms_req;
  logic [3:0]  ms_rf_we_in;
  logic [4:0]  ms_dest;
  logic [31:0] ms_rt_value;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_pc;

  assign ms_c0_bus     = es_to_ms_bus_r[EM_C0_LSB      +: 11];
  assign ms_bd         = es_to_ms_bus_r[EM_BD_BIT];
  assign ms_ex_flag    = es_to_ms_bus_r[EM_EX_BIT];
  assign ms_excode     = es_to_ms_bus_r[EM_EXCODE_LSB  +: 5];
  assign ms_is_load    = es_to_ms_bus_r[EM_IS_LOAD_BIT];
  assign ms_ld_type    = es_to_ms_bus_r[EM_LD_TYPE_LSB +: 3];
  assign ms_req        = es_to_ms_bus_r[EM_REQ_BIT];
  assign ms_rf_we_in   = es_to_ms_bus_r[EM_RF_WE_LSB   +: 4];
  assign ms_dest       = es_to_ms_bus_r[EM_DEST_LSB    +: 5];
  assign ms_rt_value   = es_to_ms_bus_r[EM_RT_LSB      +: 32];
  assign ms_alu_result = es_to_ms_bus_r[EM_ALU_LSB     +: 32];
  assign ms_pc         = es_to_ms_bus_r[EM_PC_LSB      +: 32];

  logic data_buf_valid;
  logic discard_idle;
  logic got_data;
  logic ms_ready_go;
  logic ms_leave;
  logic capture;

  assign data_buf_valid = (resp_state == RESP_HAVE);
  assign discard_idle   = (discard_cnt == 2'd0);
  // A response only belongs to this instruction once all stale ones are gone.
  assign got_data       = data_buf_valid || (data_sram_data_ok && discard_idle);
  assign ms_ready_go    = !ms_req || ms_ex_flag || got_data;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_leave       = ms_to_ws_valid && ws_allowin;
  // Buffer only when the response arrives but the instruction must stay.
  assign capture        = ms_valid && ms_req && !data_buf_valid && data_sram_data_ok &&
                          discard_idle && !ms_leave && !flush;

  // Stage valid bit: flush wins over a concurrent accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Latch the incoming instruction on an upstream transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_to_ms_bus_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  // Response state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_state <= RESP_WAIT;
    end else begin
      resp_state <= resp_state_next;
    end
  end

  // Response next state: WAIT -> HAVE on a buffered response, back on leave/flush.
  always_comb begin
    resp_state_next = resp_state;
    case (resp_state)
      RESP_WAIT: if (capture) resp_state_next = RESP_HAVE;
      RESP_HAVE: if (flush || ms_leave) resp_state_next = RESP_WAIT;
      default:   resp_state_next = RESP_WAIT;
    endcase
  end

  // Hold the response word while the instruction is stalled by write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_buf <= 32'b0;
    end else if (capture) begin
      data_buf <= data_sram_rdata;
    end
  end

  logic [1:0] flush_inc;
  logic       drop;
  logic [2:0] discard_sum;

  // A flush orphans this stage's unanswered request plus any still in ES.
  assign flush_inc   = flush ? ({1'b0, ms_valid && ms_req && !got_data} +
                                {1'b0, es_req_inflight}) : 2'd0;
  assign drop        = data_sram_data_ok && !discard_idle;
  assign discard_sum = {1'b0, discard_cnt} + {1'b0, flush_inc} - {2'b0, drop};

  // Count of stale responses still to be swallowed, saturating at 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt <= 2'd0;
    end else begin
      discard_cnt <= (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
    end
  end

  logic [31:0] ld_word;
  logic [31:0] ld_result;
  logic [3:0]  ld_mask;
  logic [31:0] ms_result;
  logic [3:0]  ms_rf_we;

  assign ld_word = data_buf_valid ? data_buf : data_sram_rdata;

  load_align u_load_align (
    .ld_type    (ms_ld_type),
    .addr_low   (ms_alu_result[1:0]),
    .rdata      (ld_word),
    .rt_value   (ms_rt_value),
    .result     (ld_result),
    .rf_we_mask (ld_mask)
  );

  // A faulting instruction must not write the register file.
  assign ms_result = (ms_is_load && !ms_ex_flag) ? ld_result : ms_alu_result;
  assign ms_rf_we  = ms_ex_flag ? 4'b0000 :
                     (ms_is_load ? (ms_rf_we_in & ld_mask) : ms_rf_we_in);

  assign ms_to_ws_bus = {ms_c0_bus, ms_bd, ms_ex_flag, ms_excode,
                         ms_rf_we, ms_dest, ms_result, ms_pc};

  assign ms_ex = ms_valid && (ms_ex_flag || ms_c0_bus[C0_ERET_BIT]);

  logic        fwd_valid;
  logic        fwd_blocked;
  logic [31:0] fwd_data;

  assign fwd_valid = ms_valid && (ms_rf_we != 4'b0000);
`ifdef MS_FWD_EN
  // Forward when the value is known; loads without data and mfc0 stall decode.
  assign fwd_blocked = fwd_valid && ((ms_is_load && !got_data) || ms_c0_bus[C0_MFC0_BIT]);
  assign fwd_data    = ms_result;
`else
  assign fwd_blocked = fwd_valid;
  assign fwd_data    = 32'b0;
`endif

  assign ms_to_ds_bus = {fwd_valid, fwd_blocked, ms_rf_we, ms_dest, fwd_data};

endmodule

// File: tb/tb_mem_resp_stage.sv
// Self-checking bench for mem_resp_stage: directed instructions, a
// transaction-level reference model compared every cycle, and literal checks.
module tb_mem_resp_stage;

  logic         clk;
  logic         reset;
  logic         es_to_ms_valid;
  logic [127:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ms_to_ws_valid;
  logic [90:0]  ms_to_ws_bus;
  logic         ws_allowin;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic         es_req_inflight;
  logic [42:0]  ms_to_ds_bus;
  logic         ms_ex;

  mem_resp_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .es_req_inflight   (es_req_inflight),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .ms_ex             (ms_ex)
  );

  // Clock and reset-time control.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] m_inst;
  logic         m_valid;
  logic         m_have;
  logic [31:0]  m_word;
  int           m_disc;

  // Register view of a load: memory bytes copied into register byte lanes.
  function automatic logic [35:0] model_load(input logic [2:0] t, input logic [1:0] a,
                                             input logic [31:0] w, input logic [31:0] rt);
    logic [7:0]  wb [4];
    logic [7:0]  rb [4];
    logic [3:0]  m;
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    int ai;
    ai = int'(a);
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    m = 4'hf;
    r = w;
    b = wb[ai];
    h = a[1] ? {wb[3], wb[2]} : {wb[1], wb[0]};
    case (t)
      3'd1: r = {{24{b[7]}}, b};
      3'd2: r = {24'h0, b};
      3'd3: r = {{16{h[15]}}, h};
      3'd4: r = {16'h0, h};
      3'd5: begin
        m = 4'h0;
        for (int i = 0; i <= ai; i++) begin
          rb[3 - ai + i] = wb[i];
          m[3 - ai + i] = 1'b1;
        end
        r = {rb[3], rb[2], rb[1], rb[0]};
      end
      3'd6: begin
        m = 4'h0;
        for (int i = 0; i <= 3 - ai; i++) begin
          rb[i] = wb[ai + i];
          m[i] = 1'b1;
        end
        r = {rb[3], rb[2], rb[1], rb[0]};
      end
      default: r = w;
    endcase
    return {m, r};
  endfunction

  function automatic logic m_got_data();
    return m_have || (data_sram_data_ok && m_disc == 0);
  endfunction
  function automatic logic m_ready_go();
    return !m_inst[105] || m_inst[115] || m_got_data();
  endfunction
  function automatic logic m_allowin();
    return !m_valid || (m_ready_go() && ws_allowin);
  endfunction
  function automatic logic m_ws_valid();
    return m_valid && m_ready_go() && !flush;
  endfunction
  function automatic logic m_leave();
    return m_ws_valid() && ws_allowin;
  endfunction
  function automatic logic [35:0] m_load();
    return model_load(m_inst[108:106], m_inst[33:32],
                      m_have ? m_word : data_sram_rdata, m_inst[95:64]);
  endfunction
  function automatic logic [31:0] m_result();
    logic [35:0] l;
    l = m_load();
    return (m_inst[109] && !m_inst[115]) ? l[31:0] : m_inst[63:32];
  endfunction
  function automatic logic [3:0] m_rf_we();
    logic [35:0] l;
    l = m_load();
    if (m_inst[115]) return 4'h0;
    return m_inst[109] ? (m_inst[104:101] & l[35:32]) : m_inst[104:101];
  endfunction
  function automatic logic [90:0] m_ws_bus();
    return {m_inst[127:110], m_rf_we(), m_inst[100:96], m_result(), m_inst[31:0]};
  endfunction
  function automatic logic [1:0] m_ds_ctl();
    logic fv;
    fv = m_valid && (m_rf_we() != 4'h0);
`ifdef MS_FWD_EN
    return {fv, fv && ((m_inst[109] && !m_got_data()) || m_inst[126])};
`else
    return {fv, fv};
`endif
  endfunction
  function automatic logic [42:0] m_ds_bus();
`ifdef MS_FWD_EN
    return {m_ds_ctl(), m_rf_we(), m_inst[100:96], m_result()};
`else
    return {m_ds_ctl(), m_rf_we(), m_inst[100:96], 32'h0};
`endif
  endfunction
  function automatic int m_next_disc();
    int n;
    n = m_disc;
    if (flush) n = n + ((m_valid && m_inst[105] && !m_got_data()) ? 1 : 0) + (es_req_inflight ? 1 : 0);
    if (data_sram_data_ok && m_disc > 0) n = n - 1;
    return (n > 3) ? 3 : n;
  endfunction
  function automatic logic m_capture();
    return m_valid && m_inst[105] && !m_have && data_sram_data_ok && m_disc == 0 &&
           !m_leave() && !flush;
  endfunction

  // Model state advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_have  <= 1'b0;
      m_disc  <= 0;
      m_inst  <= '0;
      m_word  <= '0;
    end else begin
      m_disc <= m_next_disc();
      if (flush || m_leave()) m_have <= 1'b0;
      else if (m_capture()) begin
        m_have <= 1'b1;
        m_word <= data_sram_rdata;
      end
      if (flush) m_valid <= 1'b0;
      else if (m_allowin()) m_valid <= es_to_ms_valid;
      if (es_to_ms_valid && m_allowin()) m_inst <= es_to_ms_bus;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("allowin", ms_allowin, m_allowin());
      check("ws_valid", ms_to_ws_valid, m_ws_valid());
      check("ms_ex", ms_ex, m_valid && (m_inst[115] || m_inst[127]));
      check("ds_ctl", ms_to_ds_bus[42:41], m_ds_ctl());
      if (m_ws_valid()) check("ws_bus", ms_to_ws_bus, m_ws_bus());
      if (m_valid) check("ds_bus", ms_to_ds_bus, m_ds_bus());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_in();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEADBEEF;
    flush             = 1'b0;
    es_req_inflight   = 1'b0;
  endtask

  function automatic logic [127:0] mk(input logic [10:0] c0, input logic bd, input logic ex,
                                      input logic [4:0] excode, input logic is_load,
                                      input logic [2:0] ld, input logic req, input logic [3:0] we,
                                      input logic [4:0] dest, input logic [31:0] rt,
                                      input logic [31:0] alu, input logic [31:0] pc);
    return {c0, bd, ex, excode, is_load, ld, req, we, dest, rt, alu, pc};
  endfunction

  function automatic logic [127:0] mk_load(input logic [2:0] ld, input logic [31:0] alu,
                                           input logic [31:0] rt, input logic [31:0] pc);
    return mk(11'h0, 1'b0, 1'b0, 5'h0, 1'b1, ld, 1'b1, 4'hf, 5'd8, rt, alu, pc);
  endfunction

  task automatic issue(input logic [127:0] inst);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = inst;
    step();
    es_to_ms_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  a;
    logic [31:0] w;
    logic [31:0] res;
    logic [3:0]  we;
  } tv_t;
  tv_t tv [13];

  // ---------------- directed stimulus ----------------
  initial begin
    tv[0]  = '{3'd1, 2'd3, 32'h80FFFFFF, 32'hFFFFFF80, 4'hf};
    tv[1]  = '{3'd2, 2'd3, 32'h80FFFFFF, 32'h00000080, 4'hf};
    tv[2]  = '{3'd5, 2'd1, 32'hAABBCCDD, 32'hCCDD3344, 4'hc};
    tv[3]  = '{3'd3, 2'd2, 32'h80017FFF, 32'hFFFF8001, 4'hf};
    tv[4]  = '{3'd4, 2'd2, 32'h80017FFF, 32'h00008001, 4'hf};
    tv[5]  = '{3'd6, 2'd1, 32'hAABBCCDD, 32'h11AABBCC, 4'h7};
    tv[6]  = '{3'd5, 2'd3, 32'hAABBCCDD, 32'hAABBCCDD, 4'hf};
    tv[7]  = '{3'd6, 2'd3, 32'hAABBCCDD, 32'h112233AA, 4'h1};
    tv[8]  = '{3'd1, 2'd0, 32'h1234567F, 32'h0000007F, 4'hf};
    tv[9]  = '{3'd7, 2'd2, 32'hAABBCCDD, 32'hAABBCCDD, 4'hf};
    tv[10] = '{3'd3, 2'd0, 32'h12348000, 32'hFFFF8000, 4'hf};
    tv[11] = '{3'd5, 2'd0, 32'hAABBCCDD, 32'hDD223344, 4'h8};
    tv[12] = '{3'd6, 2'd0, 32'hAABBCCDD, 32'hAABBCCDD, 4'hf};

    clear_in();
    es_to_ms_bus = '0;
    ws_allowin   = 1'b1;
    reset        = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    settle();
    check("rst_allowin", ms_allowin, 1'b1);
    check("rst_ws_valid", ms_to_ws_valid, 1'b0);
    check("rst_ws_bus", ms_to_ws_bus, 91'h0);
    check("rst_ds_bus", ms_to_ds_bus, 43'h0);
    check("rst_ms_ex", ms_ex, 1'b0);
    reset = 1'b0;
    step();

    // LW whose response arrives two cycles after it enters the stage.
    issue(mk_load(3'd0, 32'h00001000, 32'h0, 32'hBFC00100));
    settle();
    check("lw_wait_valid", ms_to_ws_valid, 1'b0);
    check("lw_wait_interlock", ms_to_ds_bus[42:41], 2'b11);
    step();
    settle();
    check("lw_wait2_valid", ms_to_ws_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h12345678;
    settle();
    check("lw_valid", ms_to_ws_valid, 1'b1);
    check("lw_result", ms_to_ws_bus[63:32], 32'h12345678);
    check("lw_pc", ms_to_ws_bus[31:0], 32'hBFC00100);
    step();
    clear_in();

    // Load alignment table, zero-latency pass-through for each entry.
    for (int i = 0; i < 13; i++) begin
      issue(mk_load(tv[i].ld, 32'h00002000 | {30'h0, tv[i].a}, 32'h11223344,
                    32'hBFC01000 + 32'(i * 4)));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = tv[i].w;
      settle();
      check($sformatf("tv%0d_valid", i), ms_to_ws_valid, 1'b1);
      check($sformatf("tv%0d_result", i), ms_to_ws_bus[63:32], tv[i].res);
      check($sformatf("tv%0d_rf_we", i), ms_to_ws_bus[72:69], tv[i].we);
      step();
      clear_in();
    end

    // Response while write-back stalls for three cycles: buffered, then delivered.
    issue(mk_load(3'd0, 32'h00003000, 32'h0, 32'hBFC00200));
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFEF00D;
    settle();
    check("stall0_allowin", ms_allowin, 1'b0);
    step();
    clear_in();
    for (int i = 1; i < 3; i++) begin
      settle();
      check($sformatf("stall%0d_allowin", i), ms_allowin, 1'b0);
      step();
    end
    ws_allowin = 1'b1;
    settle();
    check("stall_valid", ms_to_ws_valid, 1'b1);
    check("stall_result", ms_to_ws_bus[63:32], 32'hCAFEF00D);
    step();

    // Flush while waiting with one more request in flight in ES.
    issue(mk_load(3'd0, 32'h00004000, 32'h0, 32'hBFC00280));
    flush           = 1'b1;
    es_req_inflight = 1'b1;
    step();
    clear_in();
    settle();
    check("flush_discard", dut.discard_cnt, 2'd2);
    check("flush_valid", ms_to_ws_valid, 1'b0);
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk_load(3'd0, 32'h00005000, 32'h0, 32'hBFC00300);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_rdata   = 32'h22222222;
    settle();
    check("drop2_valid", ms_to_ws_valid, 1'b0);
    check("drop2_discard", dut.discard_cnt, 2'd1);
    step();
    data_sram_rdata = 32'h33333333;
    settle();
    check("after_drop_valid", ms_to_ws_valid, 1'b1);
    check("after_drop_result", ms_to_ws_bus[63:32], 32'h33333333);
    check("after_drop_pc", ms_to_ws_bus[31:0], 32'hBFC00300);
    step();
    clear_in();

    // Exception instruction without a request passes at once with no write.
    issue(mk(11'h0, 1'b1, 1'b1, 5'h0c, 1'b0, 3'd0, 1'b0, 4'hf, 5'd7, 32'h0,
             32'h00000055, 32'hBFC00400));
    settle();
    check("ex_valid", ms_to_ws_valid, 1'b1);
    check("ex_rf_we", ms_to_ws_bus[72:69], 4'h0);
    check("ex_flag", ms_to_ws_bus[79:73], {1'b1, 1'b1, 5'h0c});
    check("ex_ms_ex", ms_ex, 1'b1);
    step();

    // ERET marker also raises ms_ex.
    issue(mk(11'h400, 1'b0, 1'b0, 5'h0, 1'b0, 3'd0, 1'b0, 4'h0, 5'd0, 32'h0,
             32'h0, 32'hBFC00500));
    settle();
    check("eret_ms_ex", ms_ex, 1'b1);
    step();

    // Reset while waiting with stale responses outstanding.
    issue(mk_load(3'd0, 32'h00006000, 32'h0, 32'hBFC00600));
    flush           = 1'b1;
    es_req_inflight = 1'b1;
    step();
    clear_in();
    issue(mk_load(3'd0, 32'h00007000, 32'h0, 32'hBFC00700));
    settle();
    check("pre_rst_discard", dut.discard_cnt, 2'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    check("mid_rst_valid", dut.ms_valid, 1'b0);
    check("mid_rst_discard", dut.discard_cnt, 2'd0);
    check("mid_rst_buf", dut.data_buf_valid, 1'b0);
    check("mid_rst_ws_bus", ms_to_ws_bus, 91'h0);
    check("mid_rst_ds_bus", ms_to_ds_bus, 43'h0);
    check("mid_rst_allowin", ms_allowin, 1'b1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
